// File: rtl/wb_uart_rx_port.sv
// wb_uart_rx_port
// Wishbone-style 8-bit slave that receives an asynchronous 8N1 UART line
// into a small receive FIFO.
//
// Ports:
//   clk_i     system clock (rising edge)
//   rst_i     asynchronous active-low reset
//   stb_i     bus strobe
//   we_i      1 = write, 0 = read
//   adr_i     register address (4'h0 status, 4'h1 data)
//   dat_i     write data
//   dat_o     read data, valid while ack_o = 1, otherwise 8'h00
//   ack_o     single-cycle acknowledge
//   rx_i      UART serial input, idle high, asynchronous to clk_i
//   rx_irq_o  high while the receive FIFO is non-empty
//
// Status register: bit0 avail, bit1 overrun, bit2 framing, bit3 full,
// bit4 parity error. Writing 1 to a sticky flag bit clears it.
//
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after
// the eight data bits; a mismatching byte is discarded and sets bit4.
//
// Bus handshake: an access starts when stb_i = 1 and ack_o = 0. On that
// clock edge ack_o rises for exactly one cycle, dat_o is loaded, and any
// register side effect (pop, flag clear) happens. A strobe held high is
// therefore acknowledged on alternate cycles.

module wb_uart_rx_port #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [3:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic       rx_i,
    output logic       rx_irq_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    // ---------------- input synchroniser ----------------
    logic rx_s1, rx_s2, rxs;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
        end
    end
    assign rxs = rx_s2;

    // ---------------- receive FSM ----------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            stop_ok, frame_err;
    logic            par_bad_q, par_bad_d;
    logic            push_pend;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_bad_d = par_bad_q;
        stop_ok   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Resample at mid start bit; a high line means a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[7:1]};   // LSB arrives first
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = ^{sh_q, rxs};   // even parity: total ones must be even
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        stop_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not
                // mistaken for a new start bit.
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- bus decode ----------------
    logic access, pop, st_wr;
    logic empty, full;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          overrun, framing, parity;
    logic          push_ok, overrun_set;
    logic [7:0]    status, rd_mux;

    assign access = stb_i & ~ack_o;
    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop    = access & ~we_i & (adr_i == 4'h1) & ~empty;
    assign st_wr  = access & we_i & (adr_i == 4'h0);

    // Push slot is shared with a pop on a full FIFO: both proceed.
    assign push_ok     = push_pend & (~full | pop);
    assign overrun_set = push_pend & full & ~pop;

    assign status = {3'b000, parity, full, framing, overrun, ~empty};

    always_comb begin
        rd_mux = 8'h00;
        case (adr_i)
            4'h0:    rd_mux = status;
            4'h1:    rd_mux = empty ? 8'h00 : mem[rd_ptr];
            default: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= sh_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o     <= 1'b0;
            dat_o     <= 8'h00;
            push_pend <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun   <= 1'b0;
            framing   <= 1'b0;
            rx_irq_o  <= 1'b0;
        end else begin
            ack_o     <= access;
            dat_o     <= (access & ~we_i) ? rd_mux : 8'h00;
            push_pend <= stop_ok & ~par_bad_q;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count_q   <= count_d;
            rx_irq_o  <= (count_d != '0);
            // Set wins over a same-cycle clear.
            overrun   <= overrun_set | (overrun & ~(st_wr & dat_i[1]));
            framing   <= frame_err   | (framing & ~(st_wr & dat_i[2]));
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) parity <= 1'b0;
        else        parity <= (stop_ok & par_bad_q) | (parity & ~(st_wr & dat_i[4]));
    end
    logic unused_dat;
    assign unused_dat = ^{dat_i[7:5], dat_i[3], dat_i[0]};
`else
    assign parity = 1'b0;
    logic unused_dat;
    assign unused_dat = ^{dat_i[7:3], dat_i[0]};
`endif

endmodule

// File: tb/tb_wb_uart_rx_port.sv
// Self-checking bench for wb_uart_rx_port (CLKS_PER_BIT = 16, FIFO_DEPTH = 4).
// Bus accesses and their expected results come from a vector table; serial
// frames and timing-critical corners are hand-written sequences.

module tb_wb_uart_rx_port;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic [3:0] adr = 4'h0;
    logic [7:0] dat_w = 8'h00;
    logic       rx = 1'b1;
    logic [7:0] dat_o;
    logic       ack;
    logic       irq;

    int checks = 0;
    int failures = 0;

    wb_uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .adr_i(adr),
        .dat_i(dat_w), .dat_o(dat_o), .ack_o(ack), .rx_i(rx), .rx_irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] wd;
        logic [7:0] exp;   // expected dat_o on the ack cycle (00 for writes)
        logic       irq;   // expected rx_irq_o just before the access
    } vec_t;

    vec_t vecs [0:28];

    // One bus access: starts on the next falling edge, checks the ack
    // cycle and the idle cycle after it.
    task automatic do_vec(input int i);
        check($sformatf("irq_v%0d", i), irq, vecs[i].irq);
        @(negedge clk);
        stb = 1'b1; we = vecs[i].we; adr = vecs[i].adr; dat_w = vecs[i].wd;
        @(posedge clk); #1;
        check($sformatf("ack_v%0d", i), ack, 1'b1);
        check($sformatf("dat_v%0d", i), dat_o, vecs[i].exp);
        stb = 1'b0; we = 1'b0; dat_w = 8'h00;
        @(posedge clk); #1;
        check($sformatf("idle_v%0d", i), {ack, dat_o}, 9'h000);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) do_vec(i);
    endtask

    // Serial frame driven on falling edges: start, 8 data bits LSB first,
    // stop. With a low stop bit the line stays low extra_low more cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        if (!stop_bit) repeat (extra_low) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int acks;
        logic [7:0] pb;

        // A: single frame, unmapped read, ignored data write
        vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h01, 1'b1};
        vecs[1]  = '{1'b1, 4'h1, 8'h55, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 4'h5, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 4'h1, 8'h00, 8'hA5, 1'b1};
        vecs[4]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        // B: overrun after five frames
        vecs[5]  = '{1'b0, 4'h0, 8'h00, 8'h0B, 1'b1};
        vecs[6]  = '{1'b0, 4'h1, 8'h00, 8'h11, 1'b1};
        vecs[7]  = '{1'b0, 4'h1, 8'h00, 8'h22, 1'b1};
        vecs[8]  = '{1'b0, 4'h1, 8'h00, 8'h33, 1'b1};
        vecs[9]  = '{1'b0, 4'h1, 8'h00, 8'h44, 1'b1};
        vecs[10] = '{1'b0, 4'h1, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 8'h02, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        // C: framing error with held-low line
        vecs[13] = '{1'b0, 4'h0, 8'h00, 8'h04, 1'b0};
        vecs[14] = '{1'b1, 4'h0, 8'h04, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        // D: glitch then valid frame
        vecs[16] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        vecs[17] = '{1'b0, 4'h0, 8'h00, 8'h01, 1'b1};
        vecs[18] = '{1'b0, 4'h1, 8'h00, 8'h7E, 1'b1};
        vecs[19] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        // E: reset mid-frame
        vecs[20] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        vecs[21] = '{1'b0, 4'h1, 8'h00, 8'hF0, 1'b1};
        vecs[22] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        // F: pop coincident with push on a full FIFO
        vecs[23] = '{1'b0, 4'h1, 8'h00, 8'h11, 1'b1};
        vecs[24] = '{1'b0, 4'h1, 8'h00, 8'h22, 1'b1};
        vecs[25] = '{1'b0, 4'h1, 8'h00, 8'h33, 1'b1};
        vecs[26] = '{1'b0, 4'h1, 8'h00, 8'h44, 1'b1};
        vecs[27] = '{1'b0, 4'h1, 8'h00, 8'h66, 1'b1};
        vecs[28] = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_dat", dat_o, 8'h00);
        check("rst_irq", irq, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Strobe held high: ack on alternate cycles
        stb = 1'b1; we = 1'b0; adr = 4'h0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 1'b0;
        check("alt_ack", acks, 2);
        repeat (2) @(negedge clk);

        // A
        send_frame(8'hA5, 1'b1, 0);
        run_vecs(0, 4);

        // B
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        send_frame(8'h33, 1'b1, 0);
        send_frame(8'h44, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        run_vecs(5, 12);

        // C
        send_frame(8'h3C, 1'b0, 40);
        repeat (200) @(negedge clk);
        run_vecs(13, 15);

        // D
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        do_vec(16);
        send_frame(8'h7E, 1'b1, 0);
        run_vecs(17, 19);

        // E: a byte sits in the FIFO, then reset lands mid data bit 4
        send_frame(8'h5A, 1'b1, 0);
        pb = 8'h0F;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = pb[k];
            repeat (CPB) @(negedge clk);
        end
        rx = pb[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        #1;
        check("midrst_ack", ack, 1'b0);
        check("midrst_dat", dat_o, 8'h00);
        check("midrst_irq", irq, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        do_vec(20);
        send_frame(8'hF0, 1'b1, 0);
        run_vecs(21, 22);

        // F: fill FIFO, then time a data read onto the push cycle of 0x66.
        // rx falls at negedge N0; push lands on posedge 156, so the access
        // must start at negedge N155 (do_vec waits one negedge itself).
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        send_frame(8'h33, 1'b1, 0);
        send_frame(8'h44, 1'b1, 0);
        fork
            send_frame(8'h66, 1'b1, 0);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                do_vec(23);
            end
        join
        repeat (4) @(negedge clk);
        run_vecs(24, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_uart_rx_port.md
Name: wb_uart_rx_port

Overview:
- Wishbone-style 8-bit slave that deserialises an asynchronous 8N1 UART line into a small receive FIFO.
- Counterpart to the TX port: it consumes the serial stream a TX port produces. Shares the same bus register map style: status at 4'h0, data at 4'h1.
- Status register exposes data-available, FIFO-full, overrun and framing-error flags. rx_irq_o supports interrupt-driven polling.

Parameters:
- CLKS_PER_BIT, 434, clk_i cycles per UART bit. Must be >= 8. Sims use 16.
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2, >= 2.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  asynchronous, active-low reset
- stb_i  in  1  bus strobe
- we_i  in  1  1 = write, 0 = read
- adr_i  in  4  register address
- dat_i  in  8  write data
- dat_o  out  8  read data; valid while ack_o = 1
- ack_o  out  1  single-cycle bus acknowledge
- rx_i  in  1  UART serial input; idle high; asynchronous to clk_i
- rx_irq_o  out  1  high while the FIFO is non-empty

Behaviour:
- Reset (rst_i low, asynchronous):
  - ack_o = 0, dat_o = 8'h00.
  - FIFO empty; overrun and framing flags = 0.
  - FSM in IDLE; synchroniser flops set to 1.
  - Reset mid-frame discards the partial byte.
- Input sync: rx_i passes through a 2-flop synchroniser. Call the output rxs. The FSM uses rxs only.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter cnt is 0..CLKS_PER_BIT-1; bit index is 0..7.
- IDLE: when rxs = 0, load cnt and go to START.
- START: after CLKS_PER_BIT/2 cycles (mid start bit), resample rxs.
  - rxs = 1: glitch; return to IDLE with no push and no flag.
  - rxs = 0: go to DATA.
- DATA: sample rxs every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. After bit 7, go to STOP.
- STOP: sample at mid stop bit.
  - rxs = 1: push the byte, go to IDLE.
  - rxs = 0: set framing flag, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs = 1, then go to IDLE. This stops a break condition from re-triggering a start.
- FIFO push:
  - Push happens on the cycle after the stop-bit sample.
  - If the FIFO is full and no pop occurs that cycle: set the sticky overrun flag and drop the new byte; FIFO contents are unchanged.
  - Push and pop in the same cycle on a full FIFO: both succeed, no overrun.
- Bus timing: ack_o <= stb_i & ~ack_o. Exactly one ack-high cycle per access; stb_i held high yields ack on alternate cycles. Register side effects occur only on the cycle ack_o is set.
- Unmapped addresses: ack with dat_o = 8'h00; writes are ignored.
- Status register, adr 4'h0:
  - Read: bit0 avail (not empty), bit1 overrun, bit2 framing, bit3 full, bit4 parity error (0 unless PARITY_EN), bits7:5 = 0.
  - Write: writing 1 to bit1 or bit2 clears that flag; other bits are ignored.
  - Set wins over clear when both happen in the same cycle.
- Data register, adr 4'h1:
  - Read: returns FIFO head and pops it.
  - Read when empty: returns 8'h00, no pointer change, no flag.
  - Write: ignored, acked.
- dat_o returns to 8'h00 on cycles with ack_o = 0.
- rx_irq_o = avail, registered; it follows the FIFO count the cycle after a push or pop.
- Latency: from the rx_i falling edge to avail = 1 is 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples an even-parity bit.
  - On mismatch, set sticky status bit4 and discard the byte. The stop bit is still checked.
  - Writing 1 to status bit4 clears it.
- Undefined: no PARITY state; frames are 8N1; status bit4 reads 0.

Test Plan:
- CLKS_PER_BIT = 16, FIFO_DEPTH = 4. Serial frame 0xA5 (8N1) -> status read 8'h01, rx_irq_o = 1; data read 8'hA5; next status 8'h00, rx_irq_o = 0.
- Five back-to-back frames 0x11..0x55 with no reads -> status 8'h0B (avail, overrun, full). Four data reads return 0x11, 0x22, 0x33, 0x44; a fifth read returns 8'h00. Write status 8'h02 -> status reads 8'h00.
- Frame 0x3C with stop bit = 0, line then held low 40 cycles before rising -> status 8'h04, FIFO empty, no spurious start while the line is low. Write 8'h04 -> framing clears.
- rx_i low pulse of 5 cycles -> no push and no flags; a following valid 0x7E frame is received correctly.
- rst_i pulsed low mid DATA bit 4 of frame 0x0F -> FIFO empty, no flags. The next full frame 0xF0 is received as 8'hF0.
- FIFO full, and the data read lands on the same cycle as the push of a 5th byte 0x66 -> no overrun. Later reads return 0x22, 0x33, 0x44, 0x66.
